// File: rtl/timer_pkg.sv
// ============================================================================
// Module : timer_pkg
// Brief  : Register map, CTRL field positions and shared types of the timer bank
// Rev    : 1.0
// ============================================================================
`default_nettype none

package timer_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_CMP    = 2'd1;
    localparam logic [1:0] REG_CNT    = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_MODE_BIT   = 1;
    localparam int CTRL_PRESC_LSB  = 2;
    localparam int STATUS_PEND_BIT = 0;

    // Single-bit CTRL flags; the prescaler field width is a bank parameter.
    typedef struct packed {
        logic mode;
        logic en;
    } ctrl_t;

endpackage

`default_nettype wire

// File: rtl/n_timer_channel.sv
// ============================================================================
// Module : n_timer_channel
// Brief  : One timer channel: prescaler, counter, compare, CTRL, pending, irq
// Rev    : 1.0
// ============================================================================
`default_nettype none

module n_timer_channel
    import timer_pkg::*;
#(
    parameter int CntWidth  = 32,
    parameter int PresWidth = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr_en_i,
    input  logic [1:0]          reg_sel_i,
    input  logic [CntWidth-1:0] wdata_i,
    output logic [CntWidth-1:0] rd_val_o,
    output logic                pending_o,
    output logic                irq_o
);

    ctrl_t                 ctrl_q,    ctrl_d;
    logic [PresWidth-1:0]  presc_q,   presc_d;
    logic [PresWidth-1:0]  pcnt_q,    pcnt_d;
    logic [CntWidth-1:0]   cnt_q,     cnt_d;
    logic [CntWidth-1:0]   cmp_q,     cmp_d;
    logic                  pending_q, pending_d;
    logic                  irq_q,     irq_d;

    logic                  w_wr_ctrl;
    logic                  w_wr_cmp;
    logic                  w_wr_cnt;
    logic                  w_wr_status;
    logic                  w_pwrap;
    logic                  w_tick;
    logic                  w_match;
    logic [CntWidth-1:0]   w_ctrl_word;
    logic [CntWidth-1:0]   w_status_word;

    always_comb begin
        w_wr_ctrl   = wr_en_i && (reg_sel_i == REG_CTRL);
        w_wr_cmp    = wr_en_i && (reg_sel_i == REG_CMP);
        w_wr_cnt    = wr_en_i && (reg_sel_i == REG_CNT);
        w_wr_status = wr_en_i && (reg_sel_i == REG_STATUS);
        w_pwrap     = (pcnt_q == presc_q);
        // STATUS writes touch only pending, so they do not steal the tick;
        // that is what lets a same-cycle match win over a pending clear.
        w_tick      = ctrl_q.en && w_pwrap && !(w_wr_ctrl || w_wr_cmp || w_wr_cnt);
        w_match     = w_tick && (cnt_q == cmp_q);
    end

    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        pcnt_d    = pcnt_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        pending_d = pending_q;
        irq_d     = w_match;

        if (w_wr_ctrl) begin
            pcnt_d = '0;
        end else if (ctrl_q.en) begin
            pcnt_d = w_pwrap ? '0 : pcnt_q + PresWidth'(1);
        end

        if (w_wr_cnt) begin
            cnt_d = wdata_i;
        end else if (w_tick) begin
            cnt_d = w_match ? '0 : cnt_q + CntWidth'(1);
        end

        if (w_wr_cmp) begin
            cmp_d = wdata_i;
        end

        if (w_wr_ctrl) begin
            ctrl_d.en   = wdata_i[CTRL_EN_BIT];
            ctrl_d.mode = wdata_i[CTRL_MODE_BIT];
            presc_d     = wdata_i[CTRL_PRESC_LSB +: PresWidth];
        end else if (w_match && ctrl_q.mode) begin
            ctrl_d.en = 1'b0;
        end

        if (w_match) begin
            pending_d = 1'b1;
        end else if (w_wr_status && wdata_i[STATUS_PEND_BIT]) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q    <= '0;
            presc_q   <= '0;
            pcnt_q    <= '0;
            cnt_q     <= '0;
            cmp_q     <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            presc_q   <= presc_d;
            pcnt_q    <= pcnt_d;
            cnt_q     <= cnt_d;
            cmp_q     <= cmp_d;
            pending_q <= pending_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        w_ctrl_word                                   = '0;
        w_ctrl_word[CTRL_EN_BIT]                      = ctrl_q.en;
        w_ctrl_word[CTRL_MODE_BIT]                    = ctrl_q.mode;
        w_ctrl_word[CTRL_PRESC_LSB +: PresWidth]      = presc_q;
        w_status_word                                 = '0;
        w_status_word[STATUS_PEND_BIT]                = pending_q;

        case (reg_sel_i)
            REG_CTRL: rd_val_o = w_ctrl_word;
            REG_CMP:  rd_val_o = cmp_q;
            REG_CNT:  rd_val_o = cnt_q;
            default:  rd_val_o = w_status_word;
        endcase
    end

    assign pending_o = pending_q;
    assign irq_o     = irq_q;

endmodule

`default_nettype wire

// File: rtl/n_timer_bank.sv
// ============================================================================
// Module : n_timer_bank
// Brief  : NumCh independent timer channels behind a {channel, reg} register port
// Rev    : 1.0
// ============================================================================
`default_nettype none

module n_timer_bank
    import timer_pkg::*;
#(
    parameter int NumCh     = 4,
    parameter int CntWidth  = 32,
    parameter int PresWidth = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [$clog2(NumCh)+1:0]   addr,
    input  logic [CntWidth-1:0]        wdata,
    output logic [CntWidth-1:0]        rdata,
    output logic [NumCh-1:0]           irq,
    output logic [NumCh-1:0]           pending
);

    localparam int AddrW = $clog2(NumCh) + 2;
    localparam int ChW   = (NumCh > 1) ? $clog2(NumCh) : 1;

    logic [ChW-1:0]      w_ch;
    logic                w_ch_ok;
    logic [CntWidth-1:0] w_rd_vals [NumCh];
    logic [CntWidth-1:0] w_rd_mux;
    logic [CntWidth-1:0] rdata_q;

    // A single-channel bank has no channel field in the address.
    if (NumCh == 1) begin : g_single
        assign w_ch    = '0;
        assign w_ch_ok = 1'b1;
    end else begin : g_multi
        assign w_ch    = addr[AddrW-1:2];
        assign w_ch_ok = (int'(w_ch) < NumCh);
    end

    for (genvar i = 0; i < NumCh; i++) begin : g_ch
        logic w_sel;
        assign w_sel = w_ch_ok && (w_ch == ChW'(i));

        n_timer_channel #(
            .CntWidth  (CntWidth),
            .PresWidth (PresWidth)
        ) u_channel (
            .clk       (clk),
            .reset     (reset),
            .wr_en_i   (wr_en && w_sel),
            .reg_sel_i (addr[1:0]),
            .wdata_i   (wdata),
            .rd_val_o  (w_rd_vals[i]),
            .pending_o (pending[i]),
            .irq_o     (irq[i])
        );
    end

    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < NumCh; k++) begin
            if (w_ch_ok && (w_ch == ChW'(k))) begin
                w_rd_mux = w_rd_vals[k];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (rd_en) begin
            rdata_q <= w_rd_mux;
        end
    end

    assign rdata = rdata_q;

endmodule

`default_nettype wire
